// File: rtl/find_reference_face_if.sv
// Operand and result bundle for the reference-face search of a box/box collision.
// The driver holds the body geometry stable from start until done_out rises.
interface find_reference_face_if #(
    parameter int W = 10
);
    logic             start;
    logic [4*W-1:0]   normA_x;
    logic [4*W-1:0]   normA_y;
    logic [4*W-1:0]   vertA_x;
    logic [4*W-1:0]   vertA_y;
    logic [4*W-1:0]   vertB_x;
    logic [4*W-1:0]   vertB_y;
    logic [1:0]       referenceIndex;
    logic [W-1:0]     referenceNorm_x;
    logic [W-1:0]     referenceNorm_y;
    logic [2*W+1:0]   bestSeparation;
    logic             separating;
    logic             busy;
    logic             done_out;

    modport master (
        output start, normA_x, normA_y, vertA_x, vertA_y, vertB_x, vertB_y,
        input  referenceIndex, referenceNorm_x, referenceNorm_y,
               bestSeparation, separating, busy, done_out
    );

    modport slave (
        input  start, normA_x, normA_y, vertA_x, vertA_y, vertB_x, vertB_y,
        output referenceIndex, referenceNorm_x, referenceNorm_y,
               bestSeparation, separating, busy, done_out
    );
endinterface

// File: rtl/find_reference_face.sv
// Separating-axis search: finds the face of body A with the largest separation
// from body B, evaluating one face/vertex pair per clock over 16 cycles.
module find_reference_face #(
    parameter int W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    find_reference_face_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state;
    logic [1:0]              i, j;
    logic signed [2*W+1:0]   face_min, best_q;
    logic [1:0]              ref_idx;
    logic                    sep_q, busy_q, done_q;

    logic [W-1:0] nx_a [4];
    logic [W-1:0] ny_a [4];
    logic [W-1:0] ax_a [4];
    logic [W-1:0] ay_a [4];
    logic [W-1:0] bx_a [4];
    logic [W-1:0] by_a [4];

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            nx_a[k] = bus.normA_x[k*W +: W];
            ny_a[k] = bus.normA_y[k*W +: W];
            ax_a[k] = bus.vertA_x[k*W +: W];
            ay_a[k] = bus.vertA_y[k*W +: W];
            bx_a[k] = bus.vertB_x[k*W +: W];
            by_a[k] = bus.vertB_y[k*W +: W];
        end
    end

    logic [W-1:0]          nx, ny, ax, ay, bx, by;
    logic signed [W:0]     dx, dy;
    logic signed [2*W:0]   nx_e, ny_e, dx_e, dy_e, px, py;
    logic signed [2*W+1:0] d, m;

    // Everything is sign-extended to full width first so no product can overflow.
    always_comb begin
        nx   = nx_a[i];
        ny   = ny_a[i];
        ax   = ax_a[i];
        ay   = ay_a[i];
        bx   = bx_a[j];
        by   = by_a[j];
        dx   = {bx[W-1], bx} - {ax[W-1], ax};
        dy   = {by[W-1], by} - {ay[W-1], ay};
        nx_e = {{(W+1){nx[W-1]}}, nx};
        ny_e = {{(W+1){ny[W-1]}}, ny};
        dx_e = {{W{dx[W]}}, dx};
        dy_e = {{W{dy[W]}}, dy};
        px   = nx_e * dx_e;
        py   = ny_e * dy_e;
        d    = {px[2*W], px} + {py[2*W], py};
        if (j == 2'd0 || d < face_min)
            m = d;
        else
            m = face_min;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            face_min <= '0;
            best_q   <= '0;
            ref_idx  <= '0;
            sep_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.start) begin
            state    <= SCAN;
            i        <= '0;
            j        <= '0;
            face_min <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    face_min <= m;
                    j        <= j + 2'd1;
                    if (j == 2'd3) begin
                        i <= i + 2'd1;
                        if (i == 2'd0 || m > best_q) begin
                            best_q  <= m;
                            ref_idx <= i;
                            sep_q   <= ~m[2*W+1] && (m != '0);
                        end
                        if (i == 2'd3) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.referenceIndex  = ref_idx;
    assign bus.referenceNorm_x = nx_a[ref_idx];
    assign bus.referenceNorm_y = ny_a[ref_idx];
    assign bus.bestSeparation  = best_q;
    assign bus.separating      = sep_q;
    assign bus.busy            = busy_q;
    assign bus.done_out        = done_q;
endmodule

// File: tb/tb_find_reference_face.sv
// Directed bench for find_reference_face: table of box/box cases plus restart,
// mid-scan reset and result-hold sequences.
module tb_find_reference_face;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    find_reference_face_if #(.W(W)) bus ();
    find_reference_face #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4*W-1:0] nx, ny, ax, ay, bx, by;
        int     exp_idx;
        longint exp_best;
        int     exp_nx, exp_ny;
        int     exp_sep;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [4*W-1:0] pk(input int a, input int b, input int c, input int e);
        logic [W-1:0] ta, tb, tc, te;
        ta = a[W-1:0]; tb = b[W-1:0]; tc = c[W-1:0]; te = e[W-1:0];
        return {te, tc, tb, ta};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        bus.normA_x = v.nx; bus.normA_y = v.ny;
        bus.vertA_x = v.ax; bus.vertA_y = v.ay;
        bus.vertB_x = v.bx; bus.vertB_y = v.by;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns the number of edges from the start edge until done_out is seen.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done_out !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, " idx"},  longint'(bus.referenceIndex), longint'(v.exp_idx));
        check({tag, " best"}, longint'($signed(bus.bestSeparation)), v.exp_best);
        check({tag, " nx"},   longint'($signed(bus.referenceNorm_x)), longint'(v.exp_nx));
        check({tag, " ny"},   longint'($signed(bus.referenceNorm_y)), longint'(v.exp_ny));
        check({tag, " sep"},  longint'(bus.separating), longint'(v.exp_sep));
        check({tag, " busy"}, longint'(bus.busy), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " idx"},  longint'(bus.referenceIndex), 0);
        check({tag, " best"}, longint'($signed(bus.bestSeparation)), 0);
        check({tag, " sep"},  longint'(bus.separating), 0);
        check({tag, " busy"}, longint'(bus.busy), 0);
        check({tag, " done"}, longint'(bus.done_out), 0);
        check({tag, " nx"},   longint'($signed(bus.referenceNorm_x)), 0);
        check({tag, " ny"},   longint'($signed(bus.referenceNorm_y)), -64);
    endtask

    initial begin
        int cyc;
        int early;
        logic [1:0] h_idx;
        logic [2*W+1:0] h_best;

        vecs[0] = '{pk(0,64,0,-64), pk(-64,0,64,0), pk(-10,10,10,-10), pk(-10,-10,10,10),
                    pk(20,40,40,20), pk(-10,-10,10,10), 1, 640, 64, 0, 1};
        vecs[1] = '{pk(0,64,0,-64), pk(-64,0,64,0), pk(-10,10,10,-10), pk(-10,-10,10,10),
                    pk(5,25,25,5), pk(-10,-10,10,10), 1, -320, 64, 0, 0};
        vecs[2] = '{pk(0,64,0,-64), pk(-64,0,64,0), pk(-10,10,10,-10), pk(-10,-10,10,10),
                    pk(-10,10,10,-10), pk(-10,-10,10,10), 0, -1280, 0, -64, 0};
        vecs[3] = '{pk(-512,-512,-512,-512), pk(-512,-512,-512,-512),
                    pk(511,511,511,511), pk(511,511,511,511),
                    pk(-512,-512,-512,-512), pk(-512,-512,-512,-512), 0, 1047552, -512, -512, 1};

        bus.start = 1'b0;
        load(vecs[0]);
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            load(vecs[k]);
            pulse_start();
            check({tag, " busy_after_start"}, longint'(bus.busy), 1);
            wait_done(cyc);
            check({tag, " latency"}, longint'(cyc), 16);
            check_result(tag, vecs[k]);
        end

        // Restart: second start sampled on the 6th SCAN edge.
        load(vecs[0]);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        early = 0;
        cyc = 0;
        while (bus.done_out !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
            if (bus.done_out === 1'b1 && cyc < 16) early = 1;
        end
        check("restart early_done", longint'(early), 0);
        check("restart latency", longint'(cyc), 16);
        check_result("restart", vecs[0]);

        // Asynchronous reset in the middle of a scan.
        load(vecs[1]);
        pulse_start();
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        wait_done(cyc);
        check("after_reset latency", longint'(cyc), 16);
        check_result("after_reset", vecs[1]);

        // Hold: results frozen while start stays low and B vertices move.
        load(vecs[0]);
        pulse_start();
        wait_done(cyc);
        check("hold latency", longint'(cyc), 16);
        h_idx  = bus.referenceIndex;
        h_best = bus.bestSeparation;
        check("hold idx0", longint'(h_idx), 1);
        check("hold best0", longint'($signed(h_best)), 640);
        bus.vertB_x = pk(-300, -200, -100, 0);
        bus.vertB_y = pk(100, 200, 300, -400);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold c%0d", c),
                  longint'({bus.done_out, bus.separating, bus.referenceIndex, bus.bestSeparation}),
                  longint'({1'b1, 1'b1, 2'd1, 22'sd640}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
